// File: rtl/task_2_output.sv
// Frame output stage: collects bytes from the upstream stage, then streams them
// out followed by an XOR checksum beat, and pulses o_output_last when finished.
module task_2_output #(
  parameter int DEPTH = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_enb,
  input  logic       i_empty,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_tlast,
  output logic       o_output_last,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    csum;
  logic          overflow;
  logic [7:0]    mem [DEPTH];

  logic          full;
  logic          last_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign full    = (count == FULL_CNT);
  assign last_rd = ({1'b0, rd_ptr} == (count - CNT_ONE));
  assign wr_en   = i_enb && ((state == S_IDLE) || ((state == S_COLLECT) && !full));
  assign wr_addr = (state == S_IDLE) ? '0 : count[AW-1:0];

  // Buffer storage carries no reset; stale contents are never read before rewrite.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      csum     <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_enb) begin
            count    <= CNT_ONE;
            csum     <= i_data;
            overflow <= 1'b0;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (i_enb) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              count <= count + CNT_ONE;
              csum  <= csum ^ i_data;
            end
          end else if (i_empty) begin
            rd_ptr <= '0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_enb) overflow <= 1'b1;
          if (i_tready) begin
            if (last_rd) state <= S_CSUM;
            else         rd_ptr <= rd_ptr + PTR_ONE;
          end
        end
        S_CSUM: begin
          if (i_enb) overflow <= 1'b1;
          if (i_tready) state <= S_DONE;
        end
        S_DONE: begin
          if (i_enb) overflow <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    o_tdata = 8'h00;
    case (state)
      S_SEND:  o_tdata = mem[rd_ptr];
      S_CSUM:  o_tdata = csum;
      default: o_tdata = 8'h00;
    endcase
  end

  assign o_tvalid      = (state == S_SEND) || (state == S_CSUM);
  assign o_tlast       = (state == S_CSUM);
  assign o_output_last = (state == S_DONE);
  assign o_busy        = (state != S_IDLE);
  assign o_overflow    = overflow;

endmodule
